// File: rtl/time_set_pkg.sv
// Shared types, field encodings and BCD helpers for the time-set front-end.
// No configuration macros are used in this file.
package time_set_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDIT_HOUR = 3'd1,
        EDIT_MIN  = 3'd2,
        EDIT_SEC  = 3'd3,
        COMMIT    = 3'd4
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // Valid BCD ranges are ordered like plain binary, so a direct compare works.
    function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if ((v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v)) begin
            r = v;
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [7:0] max_v);
        logic [7:0] r;
        if (up) begin
            if (v >= max_v) begin
                r = 8'h00;
            end else if (v[3:0] >= 4'd9) begin
                r = {v[7:4] + 4'd1, 4'h0};
            end else begin
                r = v + 8'd1;
            end
        end else begin
            if ((v == 8'h00) || (v > max_v)) begin
                r = max_v;
            end else if (v[3:0] == 4'd0) begin
                r = {v[7:4] - 4'd1, 4'h9};
            end else begin
                r = v - 8'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_conditioner.sv
// Raw button -> 2-FF synchronizer -> debounce -> one-cycle press pulse.
// TIME_SET_AUTO_REPEAT_EN adds the debounced level as an extra output.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic d_clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
`ifdef TIME_SET_AUTO_REPEAT_EN
    ,
    output logic level
`endif
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then accept a new level only after enough identical samples.
    always_ff @(posedge d_clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                press_r <= sync2_r;
                cnt_r   <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign press = press_r;
`ifdef TIME_SET_AUTO_REPEAT_EN
    assign level = level_r;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven BCD time editor feeding the RTC counter's load port.
// Optional auto-repeat of up/down while held: TIME_SET_AUTO_REPEAT_EN.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int REPEAT_DELAY    = 200,
    parameter int REPEAT_PERIOD   = 50
) (
    input  logic        d_clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [23:0] full_time,
    output logic        set,
    output logic [7:0]  set_hour,
    output logic [7:0]  set_min,
    output logic [7:0]  set_sec,
    output logic [1:0]  edit_field,
    output logic        editing
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_r;
    state_e        state_next_s;
    logic [7:0]    hour_r;
    logic [7:0]    min_r;
    logic [7:0]    sec_r;
    logic [7:0]    hour_next_s;
    logic [7:0]    min_next_s;
    logic [7:0]    sec_next_s;
    logic [TW-1:0] to_cnt_r;
    logic          mode_press_s;
    logic          up_press_s;
    logic          down_press_s;
    logic          mode_ev_s;
    logic          up_ev_s;
    logic          down_ev_s;
    logic          any_ev_s;
    logic          step_s;
    logic          in_edit_s;
    logic          timeout_s;
`ifdef TIME_SET_AUTO_REPEAT_EN
    logic          mode_lvl_s;
    logic          up_lvl_s;
    logic          down_lvl_s;
`endif

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .d_clk   (d_clk),
        .rst     (rst),
        .btn_raw (btn_mode),
        .press   (mode_press_s)
`ifdef TIME_SET_AUTO_REPEAT_EN
        ,
        .level   (mode_lvl_s)
`endif
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .d_clk   (d_clk),
        .rst     (rst),
        .btn_raw (btn_up),
        .press   (up_press_s)
`ifdef TIME_SET_AUTO_REPEAT_EN
        ,
        .level   (up_lvl_s)
`endif
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .d_clk   (d_clk),
        .rst     (rst),
        .btn_raw (btn_down),
        .press   (down_press_s)
`ifdef TIME_SET_AUTO_REPEAT_EN
        ,
        .level   (down_lvl_s)
`endif
    );

    assign mode_ev_s = mode_press_s;
    assign in_edit_s = (state_r == EDIT_HOUR) || (state_r == EDIT_MIN) || (state_r == EDIT_SEC);

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic          rep_held_s;
    logic          rep_fire_s;
    logic          rep_armed_r;
    logic          rep_block_r;
    logic [RW-1:0] rep_cnt_r;

    // A mode press blocks repeat until both up and down have been let go.
    assign rep_held_s = in_edit_s && (up_lvl_s ^ down_lvl_s) && !rep_block_r
                        && !mode_lvl_s && !mode_press_s;
    assign rep_fire_s = rep_held_s && (rep_armed_r ? (rep_cnt_r == PER_LAST)
                                                   : (rep_cnt_r == DLY_LAST));
    assign up_ev_s    = up_press_s   | (rep_fire_s & up_lvl_s);
    assign down_ev_s  = down_press_s | (rep_fire_s & down_lvl_s);

    // Repeat timer: initial delay, then a fixed period while the button is held.
    always_ff @(posedge d_clk) begin
        if (rst) begin
            rep_cnt_r   <= {RW{1'b0}};
            rep_armed_r <= 1'b0;
            rep_block_r <= 1'b0;
        end else begin
            if (mode_press_s) begin
                rep_block_r <= 1'b1;
            end else if (!up_lvl_s && !down_lvl_s) begin
                rep_block_r <= 1'b0;
            end else begin
                rep_block_r <= rep_block_r;
            end
            if (!rep_held_s) begin
                rep_cnt_r   <= {RW{1'b0}};
                rep_armed_r <= 1'b0;
            end else if (rep_fire_s) begin
                rep_cnt_r   <= {RW{1'b0}};
                rep_armed_r <= 1'b1;
            end else begin
                rep_cnt_r   <= rep_cnt_r + {{(RW-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    assign up_ev_s   = up_press_s;
    assign down_ev_s = down_press_s;
`endif

    assign any_ev_s  = mode_ev_s | up_ev_s | down_ev_s;
    assign step_s    = up_ev_s ^ down_ev_s;
    assign timeout_s = in_edit_s && !any_ev_s && (to_cnt_r == TO_LAST);

    // Next state and edit-register update; mode outranks up/down.
    always_comb begin
        state_next_s = state_r;
        hour_next_s  = hour_r;
        min_next_s   = min_r;
        sec_next_s   = sec_r;
        case (state_r)
            IDLE: begin
                if (mode_ev_s) begin
                    state_next_s = EDIT_HOUR;
                    hour_next_s  = bcd_sanitize(full_time[23:16], HOUR_MAX);
                    min_next_s   = bcd_sanitize(full_time[15:8], MINSEC_MAX);
                    sec_next_s   = bcd_sanitize(full_time[7:0], MINSEC_MAX);
                end else begin
                    state_next_s = IDLE;
                end
            end
            EDIT_HOUR: begin
                if (mode_ev_s) begin
                    state_next_s = EDIT_MIN;
                end else if (step_s) begin
                    hour_next_s = bcd_step(hour_r, up_ev_s, HOUR_MAX);
                end else if (timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = EDIT_HOUR;
                end
            end
            EDIT_MIN: begin
                if (mode_ev_s) begin
                    state_next_s = EDIT_SEC;
                end else if (step_s) begin
                    min_next_s = bcd_step(min_r, up_ev_s, MINSEC_MAX);
                end else if (timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = EDIT_MIN;
                end
            end
            EDIT_SEC: begin
                if (mode_ev_s) begin
                    state_next_s = COMMIT;
                end else if (step_s) begin
                    sec_next_s = bcd_step(sec_r, up_ev_s, MINSEC_MAX);
                end else if (timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = EDIT_SEC;
                end
            end
            COMMIT:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, edit registers and idle timer.
    always_ff @(posedge d_clk) begin
        if (rst) begin
            state_r  <= IDLE;
            hour_r   <= 8'h00;
            min_r    <= 8'h00;
            sec_r    <= 8'h00;
            to_cnt_r <= {TW{1'b0}};
        end else begin
            state_r <= state_next_s;
            hour_r  <= hour_next_s;
            min_r   <= min_next_s;
            sec_r   <= sec_next_s;
            if (!in_edit_s || any_ev_s || (state_next_s != state_r)) begin
                to_cnt_r <= {TW{1'b0}};
            end else begin
                to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Registered outputs; set_* only move on a commit.
    always_ff @(posedge d_clk) begin
        if (rst) begin
            set        <= 1'b0;
            set_hour   <= 8'h00;
            set_min    <= 8'h00;
            set_sec    <= 8'h00;
            edit_field <= FIELD_NONE;
            editing    <= 1'b0;
        end else begin
            set     <= (state_r == COMMIT);
            editing <= in_edit_s;
            if (state_r == COMMIT) begin
                set_hour <= hour_r;
                set_min  <= min_r;
                set_sec  <= sec_r;
            end else begin
                set_hour <= set_hour;
                set_min  <= set_min;
                set_sec  <= set_sec;
            end
            case (state_r)
                EDIT_HOUR: edit_field <= FIELD_HOUR;
                EDIT_MIN:  edit_field <= FIELD_MIN;
                EDIT_SEC:  edit_field <= FIELD_SEC;
                default:   edit_field <= FIELD_NONE;
            endcase
        end
    end

endmodule
